// File: rtl/addsub24_arbiter.sv
// Round-robin arbiter sharing one combinational 24-bit add/sub unit between NUM_REQ requesters.
// Define ADDSUB24_ARB_CHAIN_EN to honour req_lock and chain carries across consecutive words.
module addsub24_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*24-1:0]    req_a,
  input  logic [NUM_REQ*24-1:0]    req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [23:0]              au_in1,
  output logic [23:0]              au_in2,
  output logic                     au_add_sub,
  output logic                     au_carry_in,
  input  logic [23:0]              au_sum,
  input  logic                     au_carry_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [23:0]              res_sum,
  output logic                     res_cout,
  output logic [ID_W-1:0]          res_id,
  output logic [TAG_W-1:0]         res_tag
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    nxt_ptr;
  logic               found;
  logic               can_issue;
  logic               grant;
  logic               locked;
  logic [TAG_W-1:0]   tag_sel;

`ifdef ADDSUB24_ARB_CHAIN_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t          state;
  logic [ID_W-1:0] lock_id;
  logic            chain_c;

  assign locked = (state == LOCKED);
`else
  logic unused_lock;

  assign locked      = 1'b0;
  assign unused_lock = ^req_lock;
`endif

  assign can_issue = !res_valid || res_ready;

  // While locked, only the chain owner is eligible for the search.
  always_comb begin
    elig = req_valid;
`ifdef ADDSUB24_ARB_CHAIN_EN
    if (locked) elig = req_valid & (NUM_REQ'(1) << lock_id);
`endif
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = ID_W'(j);
      end
    end
  end

  assign grant     = found && can_issue && !rst;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign sel       = grant ? win : '0;
  assign nxt_ptr   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  assign au_in1     = req_a[24*int'(sel) +: 24];
  assign au_in2     = req_b[24*int'(sel) +: 24];
  assign au_add_sub = req_sub[sel];
  assign tag_sel    = req_tag[TAG_W*int'(sel) +: TAG_W];

  // Words after the first in a chain take the carry saved from the previous word.
`ifdef ADDSUB24_ARB_CHAIN_EN
  assign au_carry_in = locked ? chain_c : req_sub[sel];
`else
  assign au_carry_in = req_sub[sel];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= '0;
      res_tag   <= '0;
      rr_ptr    <= '0;
`ifdef ADDSUB24_ARB_CHAIN_EN
      state     <= ARB;
      lock_id   <= '0;
      chain_c   <= 1'b0;
`endif
    end else begin
      if (grant) begin
        res_valid <= 1'b1;
        res_sum   <= au_sum;
        res_cout  <= au_carry_out;
        res_id    <= win;
        res_tag   <= tag_sel;
        rr_ptr    <= nxt_ptr;
`ifdef ADDSUB24_ARB_CHAIN_EN
        chain_c   <= au_carry_out;
        case (state)
          ARB: if (req_lock[win]) begin
            state   <= LOCKED;
            lock_id <= win;
          end
          LOCKED: if (!req_lock[win]) state <= ARB;
          default: state <= ARB;
        endcase
`endif
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub24_arbiter.sv
// Directed bench for addsub24_arbiter with a behavioural add/sub unit and a result scoreboard.
module tb_addsub24_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req_valid, req_ready, req_sub, req_lock;
  logic [95:0]        req_a, req_b;
  logic [15:0]        req_tag;
  logic [23:0]        au_in1, au_in2, au_sum;
  logic               au_add_sub, au_carry_in, au_carry_out;
  logic               res_valid, res_ready, res_cout;
  logic [23:0]        res_sum;
  logic [1:0]         res_id;
  logic [3:0]         res_tag;
  logic [24:0]        au_full;

  typedef struct packed {
    logic [23:0] sum;
    logic        cout;
    logic [1:0]  id;
    logic [3:0]  tag;
  } res_t;

  res_t sb[$];
  res_t last;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Shared unit: subtract is A + ~B + carry_in.
  assign au_full      = {1'b0, au_in1} + {1'b0, (au_add_sub ? ~au_in2 : au_in2)} + 25'(au_carry_in);
  assign au_sum       = au_full[23:0];
  assign au_carry_out = au_full[24];

  addsub24_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_lock(req_lock), .req_tag(req_tag),
    .au_in1(au_in1), .au_in2(au_in2), .au_add_sub(au_add_sub), .au_carry_in(au_carry_in),
    .au_sum(au_sum), .au_carry_out(au_carry_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .res_tag(res_tag)
  );

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [23:0] a, input logic [23:0] b,
                         input logic sub, input logic lock, input logic [3:0] tag);
    req_valid[i]            = v;
    req_a[24*i +: 24]       = a;
    req_b[24*i +: 24]       = b;
    req_sub[i]              = sub;
    req_lock[i]             = lock;
    req_tag[TAG_W*i +: TAG_W] = tag;
  endtask

  // One clock cycle: check grant and pending result, update the scoreboard, advance.
  task automatic cyc(input logic [3:0] exp_rdy, input logic exp_cin, input string nm);
    res_t        e;
    int          w;
    logic [23:0] a, b;
    logic [24:0] tot;
    #1;
    chk({nm, ":req_ready"}, req_ready, exp_rdy);
    chk({nm, ":res_valid"}, res_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      e = sb[0];
      chk({nm, ":res_sum"}, res_sum, e.sum);
      chk({nm, ":res_cout"}, res_cout, e.cout);
      chk({nm, ":res_id"}, res_id, e.id);
      chk({nm, ":res_tag"}, res_tag, e.tag);
      if (res_ready) last = sb.pop_front();
    end
    if (exp_rdy != 0) begin
      w = 0;
      for (int k = 0; k < NUM_REQ; k++) if (exp_rdy[k]) w = k;
      a = req_a[24*w +: 24];
      b = req_b[24*w +: 24];
      chk({nm, ":au_in1"}, au_in1, a);
      chk({nm, ":au_carry_in"}, au_carry_in, exp_cin);
      tot   = {1'b0, a} + {1'b0, (req_sub[w] ? ~b : b)} + 25'(exp_cin);
      e.sum  = tot[23:0];
      e.cout = tot[24];
      e.id   = 2'(w);
      e.tag  = req_tag[TAG_W*w +: TAG_W];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    req_valid = '0; req_sub = '0; req_lock = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    chk("rst:req_ready", req_ready, 4'b0000);
    chk("rst:res_valid", res_valid, 1'b0);
    chk("rst:res_sum", res_sum, 24'h0);
    chk("rst:res_cout", res_cout, 1'b0);
    chk("rst:res_id", res_id, 2'd0);
    chk("rst:res_tag", res_tag, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = '0; res_ready = 1'b1;

    // Requester 2 add with carry-out.
    set_req(2, 1'b1, 24'h000001, 24'hFFFFFF, 1'b0, 1'b0, 4'h5);
    cyc(4'b0100, 1'b0, "add2");
    req_valid = '0;
    cyc(4'b0000, 1'b0, "drain2");
    chk("add2:sum", last.sum, 24'h000000);
    chk("add2:cout", last.cout, 1'b1);
    chk("add2:id", last.id, 2'd2);
    chk("add2:tag", last.tag, 4'h5);

    // All valid: round-robin resumes after requester 2.
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'b1, 24'h123456 * (i + 1), 24'h0F0F0F + 24'(i), i[0], 1'b0, 4'(i + 8));
    for (int k = 0; k < 5; k++) begin
      int w;
      w = (3 + k) % NUM_REQ;
      cyc(4'(1 << w), req_sub[w], "rr");
    end
    req_valid = '0;
    cyc(4'b0000, 1'b0, "rr_drain");

    // Requester 1 subtract, then backpressure with others waiting.
    set_req(1, 1'b1, 24'h000005, 24'h000007, 1'b1, 1'b0, 4'h3);
    cyc(4'b0010, 1'b1, "sub1");
    set_req(1, 1'b0, 24'h000005, 24'h000007, 1'b1, 1'b0, 4'h3);
    set_req(0, 1'b1, 24'h00ABCD, 24'h001111, 1'b0, 1'b0, 4'h1);
    set_req(3, 1'b1, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 4'h7);
    res_ready = 1'b0;
    cyc(4'b0000, 1'b0, "hold_a");
    cyc(4'b0000, 1'b0, "hold_b");
    res_ready = 1'b1;
    cyc(4'b1000, 1'b0, "release");
    chk("sub1:sum", last.sum, 24'hFFFFFE);
    chk("sub1:cout", last.cout, 1'b0);
    chk("sub1:id", last.id, 2'd1);
    req_valid[3] = 1'b0;
    cyc(4'b0001, 1'b0, "after_release");
    req_valid = '0;
    cyc(4'b0000, 1'b0, "bp_drain");

    // Empty register accepts even with res_ready low; then it must stall.
    res_ready = 1'b0;
    set_req(2, 1'b1, 24'h400000, 24'h400000, 1'b0, 1'b0, 4'hA);
    cyc(4'b0100, 1'b0, "empty_issue");
    cyc(4'b0000, 1'b0, "full_stall");
    req_valid = '0; res_ready = 1'b1;
    cyc(4'b0000, 1'b0, "stall_drain");

    // Requester 3 chain (low word locked) with requester 0 competing.
    set_req(3, 1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1, 4'hC);
    set_req(0, 1'b1, 24'h000010, 24'h000020, 1'b0, 1'b0, 4'h2);
`ifdef ADDSUB24_ARB_CHAIN_EN
    cyc(4'b1000, 1'b0, "chain_lo");
    req_valid[3] = 1'b0;
    cyc(4'b0000, 1'b0, "chain_gap");
    set_req(3, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0, 4'hD);
    cyc(4'b1000, 1'b1, "chain_hi");
    req_valid[3] = 1'b0;
    cyc(4'b0001, 1'b0, "chain_after");
    chk("chain_hi:sum", last.sum, 24'h000001);
    chk("chain_hi:id", last.id, 2'd3);
`else
    cyc(4'b1000, 1'b0, "nolock_3");
    req_valid[3] = 1'b0;
    cyc(4'b0001, 1'b0, "nolock_0");
`endif
    req_valid = '0;
    cyc(4'b0000, 1'b0, "chain_drain");

    // Reset while locked with a pending result.
    set_req(3, 1'b1, 24'h00F000, 24'h000F00, 1'b0, 1'b1, 4'hE);
    cyc(4'b1000, 1'b0, "lock_pre_rst");
    rst = 1'b1; res_ready = 1'b0; req_valid = 4'b1111;
    #1;
    chk("mid_rst:req_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_rst:res_valid", res_valid, 1'b0);
    chk("post_rst:res_sum", res_sum, 24'h0);
    sb.delete();
    rst = 1'b0; res_ready = 1'b1; req_lock = '0;
    cyc(4'b0001, req_sub[0], "post_rst_grant");
    req_valid = '0;
    cyc(4'b0000, 1'b0, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
